cache_tag_array: RTL and testbench
==================================

# cache_tag_array

Parametrised N-way set-associative tag store for the L1 I/D caches. Each way holds, per set, a tag plus valid and dirty bits. The block provides:
- a one-cycle-latency lookup port with hit detection, per-way dirty status and a victim-way suggestion;
- a single write port with write-first bypass to a same-cycle lookup;
- a self-clearing sweep after reset and on a flush request.

It sits between the cache controller FSM and the pipeline address stage.

## Interface
Parameters:
- TAG_WIDTH, 20, tag bits per entry
- INDEX_WIDTH, 7, set index bits; SETS = 2**INDEX_WIDTH
- NUM_WAYS, 2, associativity (1..8)

Ports:
- clk  in  1  single clock; all logic rising-edge
- resetn  in  1  synchronous, active-low reset
- lk_req  in  1  lookup request
- lk_index  in  INDEX_WIDTH  lookup set
- lk_tag  in  TAG_WIDTH  tag to compare
- rs_valid  out  1  lookup result valid
- rs_hit  out  1  any way matched
- rs_hit_way  out  NUM_WAYS  one-hot per matching way
- rs_dirty  out  NUM_WAYS  dirty bit of each way in looked-up set
- rs_victim_way  out  NUM_WAYS  one-hot suggested replacement way
- rs_victim_tag  out  TAG_WIDTH  stored tag of suggested victim
- wr_en  in  1  write request
- wr_index  in  INDEX_WIDTH  write set
- wr_way  in  NUM_WAYS  one-hot way select
- wr_tag  in  TAG_WIDTH  tag to store
- wr_v  in  1  valid bit to store
- wr_d  in  1  dirty bit to store
- flush_req  in  1  invalidate all entries
- flush_done  out  1  one-cycle pulse when a flush sweep completes
- ready  out  1  array accepts lookups and writes

## Operation
- Storage per way: SETS entries of {v, d, tag}, inferred as block RAM.
- FSM states:
  - INIT: entered on reset. The sweep counter writes {0,0,0} to set `cnt` in all ways each cycle. When cnt == SETS-1, go to READY.
  - READY: normal operation, ready = 1.
  - FLUSH: same sweep as INIT. On completion, go to READY and pulse flush_done.
- Requests in INIT and FLUSH:
  - lk_req and wr_en are ignored.
  - flush_req is ignored; no queuing.
- flush_req is accepted only in READY. A write in the same cycle as flush_req is performed first, then the flush erases it.
- Hit rule: way w hits when v[w] == 1 and tag[w] == lk_tag.
  - rs_hit = OR of rs_hit_way.
  - Multiple hits are reported raw. Preventing them is the controller's responsibility.
- Victim selection:
  - Lowest-numbered invalid way, if any.
  - Otherwise the way pointed to by a global round-robin pointer. The pointer advances by one (mod NUM_WAYS) on every write with wr_v = 1.
- Write:
  - In READY with wr_en = 1, every way with a set wr_way bit gets {wr_v, wr_d, wr_tag} at wr_index.
  - wr_way = 0 is a no-op.
- Write-first bypass: if wr_en and lk_req fall in the same READY cycle with wr_index == lk_index, the result uses the newly written entry for the written ways.
- Reset mid-sweep or mid-lookup:
  - The FSM returns to INIT with cnt = 0.
  - Any pending result is dropped: rs_valid = 0 the next cycle.

## Timing
- Reset values (all applied on the first clock edge with resetn = 0):
  - ready = 0, rs_valid = 0, rs_hit = 0, rs_hit_way = 0, rs_dirty = 0
  - rs_victim_way = 0, rs_victim_tag = 0, flush_done = 0
  - round-robin pointer = 0, state = INIT, cnt = 0
- INIT and FLUSH each last exactly SETS cycles. ready rises on the cycle after the last sweep write.
- Lookup latency is 1 cycle: request at cycle N (ready = 1) gives rs_* valid at N+1 with rs_valid = 1. Fully pipelined, one lookup per cycle.
- rs_* other than rs_valid hold their last value when rs_valid = 0.
- A write at cycle N is visible to a lookup issued at cycle N (bypass) and to all later lookups.
- flush_req accepted at cycle N:
  - ready = 0 from N+1.
  - flush_done = 1 during the cycle ready returns to 1, i.e. N+SETS+1.
  - A lookup issued at cycle N still returns a result at N+1.

## Test plan
- Reset release, INDEX_WIDTH = 7: ready = 0 for 128 cycles, then 1. A lookup of any index/tag gives rs_valid = 1, rs_hit = 0, rs_victim_way = 2'b01.
- Write set 5 way 1 {v=1, d=1, tag=0xABCDE}, then look up set 5 tag 0xABCDE: rs_hit = 1, rs_hit_way = 2'b10, rs_dirty = 2'b10, rs_victim_way = 2'b01.
- Same-cycle write of set 9 way 0 tag 0x12345 and lookup of set 9 tag 0x12345: the next cycle gives rs_hit = 1, rs_hit_way = 2'b01.
- Fill both ways of set 3 valid, then look up a missing tag: rs_hit = 0 and the victim follows the round-robin pointer. After one more write with wr_v = 1, the victim toggles.
- flush_req after populating entries: ready low for 128 cycles, flush_done pulses once, then every previously hit tag misses.
- Assert resetn = 0 for 1 cycle midway through a FLUSH: no flush_done. INIT restarts at cnt = 0 and ready returns 128 cycles later.

Source files
------------

// File: rtl/cache_tag_array.sv
// N-way set-associative tag store: 1-cycle lookup with hit/dirty/victim, write-first bypass,
// self-clearing sweep after reset and on flush. Requests are dropped while ready = 0.
module cache_tag_array #(
  parameter int TAG_WIDTH   = 20,
  parameter int INDEX_WIDTH = 7,
  parameter int NUM_WAYS    = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   lk_req,
  input  logic [INDEX_WIDTH-1:0] lk_index,
  input  logic [TAG_WIDTH-1:0]   lk_tag,
  output logic                   rs_valid,
  output logic                   rs_hit,
  output logic [NUM_WAYS-1:0]    rs_hit_way,
  output logic [NUM_WAYS-1:0]    rs_dirty,
  output logic [NUM_WAYS-1:0]    rs_victim_way,
  output logic [TAG_WIDTH-1:0]   rs_victim_tag,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [NUM_WAYS-1:0]    wr_way,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic                   wr_v,
  input  logic                   wr_d,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic                   ready
);

  localparam int SETS  = 2 ** INDEX_WIDTH;
  localparam int PTR_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {S_INIT, S_READY, S_FLUSH} state_t;

  typedef struct packed {
    logic                 v;
    logic                 d;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t tag_mem [NUM_WAYS][SETS];

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]       rr_q, rr_d;
  logic                   flush_done_q, flush_done_d;
  logic                   rs_valid_q, rs_valid_d;
  logic                   rs_hit_q, rs_hit_d;
  logic [NUM_WAYS-1:0]    rs_hit_way_q, rs_hit_way_d;
  logic [NUM_WAYS-1:0]    rs_dirty_q, rs_dirty_d;
  logic [NUM_WAYS-1:0]    rs_victim_way_q, rs_victim_way_d;
  logic [TAG_WIDTH-1:0]   rs_victim_tag_q, rs_victim_tag_d;

  logic   is_ready, sweep, wr_fire, lk_fire;
  entry_t wr_entry;

  assign is_ready = (state_q == S_READY);
  assign sweep    = !is_ready;
  assign wr_fire  = is_ready && wr_en;
  assign lk_fire  = is_ready && lk_req;
  assign wr_entry = {wr_v, wr_d, wr_tag};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    case (state_q)
      S_INIT, S_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INDEX_WIDTH'(SETS - 1)) begin
          state_d      = S_READY;
          cnt_d        = '0;
          flush_done_d = (state_q == S_FLUSH);
        end
      end
      S_READY: begin
        if (flush_req) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Pointer moves on every accepted valid write, independent of which set it hits.
  always_comb begin
    rr_d = rr_q;
    if (wr_fire && wr_v && (|wr_way)) begin
      rr_d = (rr_q == PTR_W'(NUM_WAYS - 1)) ? '0 : rr_q + 1'b1;
    end
  end

  entry_t              rd_entry [NUM_WAYS];
  logic [NUM_WAYS-1:0] hit_way, dirty_way, victim_way;
  logic [TAG_WIDTH-1:0] victim_tag;
  logic                found_inv;

  always_comb begin
    hit_way    = '0;
    dirty_way  = '0;
    victim_way = '0;
    victim_tag = '0;
    found_inv  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      rd_entry[w] = tag_mem[w][lk_index];
      if (wr_fire && wr_way[w] && (wr_index == lk_index)) begin
        rd_entry[w] = wr_entry;
      end
      hit_way[w]   = rd_entry[w].v && (rd_entry[w].tag == lk_tag);
      dirty_way[w] = rd_entry[w].d;
      if (!found_inv && !rd_entry[w].v) begin
        victim_way[w] = 1'b1;
        found_inv     = 1'b1;
      end
    end
    if (!found_inv) begin
      victim_way = NUM_WAYS'(1) << rr_q;
    end
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (victim_way[w]) begin
        victim_tag = rd_entry[w].tag;
      end
    end
  end

  always_comb begin
    rs_valid_d      = lk_fire;
    rs_hit_d        = rs_hit_q;
    rs_hit_way_d    = rs_hit_way_q;
    rs_dirty_d      = rs_dirty_q;
    rs_victim_way_d = rs_victim_way_q;
    rs_victim_tag_d = rs_victim_tag_q;
    if (lk_fire) begin
      rs_hit_d        = |hit_way;
      rs_hit_way_d    = hit_way;
      rs_dirty_d      = dirty_way;
      rs_victim_way_d = victim_way;
      rs_victim_tag_d = victim_tag;
    end
  end

  // Storage has no reset; the sweep clears one set per cycle in all ways.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (sweep) begin
          tag_mem[w][cnt_q] <= '0;
        end else if (wr_fire && wr_way[w]) begin
          tag_mem[w][wr_index] <= wr_entry;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= S_INIT;
      cnt_q           <= '0;
      rr_q            <= '0;
      flush_done_q    <= 1'b0;
      rs_valid_q      <= 1'b0;
      rs_hit_q        <= 1'b0;
      rs_hit_way_q    <= '0;
      rs_dirty_q      <= '0;
      rs_victim_way_q <= '0;
      rs_victim_tag_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rr_q            <= rr_d;
      flush_done_q    <= flush_done_d;
      rs_valid_q      <= rs_valid_d;
      rs_hit_q        <= rs_hit_d;
      rs_hit_way_q    <= rs_hit_way_d;
      rs_dirty_q      <= rs_dirty_d;
      rs_victim_way_q <= rs_victim_way_d;
      rs_victim_tag_q <= rs_victim_tag_d;
    end
  end

  assign ready         = is_ready;
  assign flush_done    = flush_done_q;
  assign rs_valid      = rs_valid_q;
  assign rs_hit        = rs_hit_q;
  assign rs_hit_way    = rs_hit_way_q;
  assign rs_dirty      = rs_dirty_q;
  assign rs_victim_way = rs_victim_way_q;
  assign rs_victim_tag = rs_victim_tag_q;

endmodule

// File: tb/tb_cache_tag_array.sv
// Randomized scoreboard bench for cache_tag_array against an array-based reference model.
module tb_cache_tag_array;

  localparam int TW   = 20;
  localparam int IW   = 7;
  localparam int NW   = 2;
  localparam int SETS = 128;

  logic          clk = 1'b0;
  logic          resetn;
  logic          lk_req;
  logic [IW-1:0] lk_index;
  logic [TW-1:0] lk_tag;
  logic          rs_valid, rs_hit;
  logic [NW-1:0] rs_hit_way, rs_dirty, rs_victim_way;
  logic [TW-1:0] rs_victim_tag;
  logic          wr_en;
  logic [IW-1:0] wr_index;
  logic [NW-1:0] wr_way;
  logic [TW-1:0] wr_tag;
  logic          wr_v, wr_d;
  logic          flush_req, flush_done, ready;

  cache_tag_array #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .NUM_WAYS(NW)) dut (
    .clk(clk), .resetn(resetn),
    .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag),
    .rs_valid(rs_valid), .rs_hit(rs_hit), .rs_hit_way(rs_hit_way), .rs_dirty(rs_dirty),
    .rs_victim_way(rs_victim_way), .rs_victim_tag(rs_victim_tag),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_tag(wr_tag),
    .wr_v(wr_v), .wr_d(wr_d),
    .flush_req(flush_req), .flush_done(flush_done), .ready(ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fd_cnt = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (flush_done) fd_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain per-way arrays plus a replacement counter.
  bit            mv [NW][SETS];
  bit            md [NW][SETS];
  logic [TW-1:0] mt [NW][SETS];
  int            rr;

  typedef struct {
    int            cyc;
    logic          hit;
    logic [NW-1:0] hw;
    logic [NW-1:0] dty;
    logic [NW-1:0] vw;
    logic [TW-1:0] vt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int            key_i[$];
  logic [TW-1:0] key_t[$];
  logic [TW-1:0] pool[4];

  function automatic void model_clear();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < SETS; s++) begin
        mv[w][s] = 1'b0; md[w][s] = 1'b0; mt[w][s] = '0;
      end
  endfunction

  function automatic exp_t model_lookup(input int i, input logic [TW-1:0] t);
    exp_t e;
    int   vic = -1;
    e.cyc = cyc; e.hw = '0; e.dty = '0; e.vw = '0;
    for (int w = 0; w < NW; w++) begin
      e.hw[w]  = mv[w][i] && (mt[w][i] == t);
      e.dty[w] = md[w][i];
      if (vic < 0 && !mv[w][i]) vic = w;
    end
    if (vic < 0) vic = rr;
    e.vw[vic] = 1'b1;
    e.vt  = mt[vic][i];
    e.hit = |e.hw;
    return e;
  endfunction

  task automatic idle();
    lk_req = 0; wr_en = 0; flush_req = 0;
  endtask

  // Called at a negedge while the array is expected to be ready.
  task automatic issue(input bit do_lk, input int li, input logic [TW-1:0] lt,
                       input bit do_wr, input int wi, input logic [NW-1:0] ww,
                       input logic [TW-1:0] wt, input bit wv, input bit wd, input bit do_fl);
    lk_req = do_lk; lk_index = li[IW-1:0]; lk_tag = lt;
    wr_en = do_wr; wr_index = wi[IW-1:0]; wr_way = ww; wr_tag = wt; wr_v = wv; wr_d = wd;
    flush_req = do_fl;
    if (do_wr)
      for (int w = 0; w < NW; w++)
        if (ww[w]) begin mv[w][wi] = wv; md[w][wi] = wd; mt[w][wi] = wt; end
    if (do_lk) sb.push_back(model_lookup(li, lt));
    if (do_wr && wv && ww != 0) begin
      rr = (rr + 1) % NW;
      key_i.push_back(wi); key_t.push_back(wt);
    end
    if (do_fl) model_clear();
    @(negedge clk);
    idle();
  endtask

  // Counts not-ready cycles from the current one while throwing requests that must be ignored.
  task automatic sweep_wait(output int n);
    n = 0;
    while (!ready && n < 1000) begin
      lk_req = 1; lk_index = IW'($urandom); lk_tag = pool[$urandom_range(0, 3)];
      wr_en = 1'($urandom); wr_index = IW'($urandom_range(0, 3)); wr_way = NW'($urandom);
      wr_tag = pool[$urandom_range(0, 3)]; wr_v = 1; wr_d = 1'($urandom);
      flush_req = ($urandom_range(0, 7) == 0);
      n++;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic random_traffic(input int ncyc);
    int li, wi;
    for (int k = 0; k < ncyc; k++) begin
      li = $urandom_range(0, 3);
      wi = ($urandom_range(0, 1) == 1) ? li : $urandom_range(0, 3);
      issue($urandom_range(0, 3) != 0, li, pool[$urandom_range(0, 3)],
            $urandom_range(0, 2) == 0, wi, NW'($urandom_range(0, 3)), pool[$urandom_range(0, 3)],
            $urandom_range(0, 3) != 0, 1'($urandom), 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (rs_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rs_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", cyc, mon_e.cyc + 1);
        chk("rs_hit", rs_hit, mon_e.hit);
        chk("rs_hit_way", rs_hit_way, mon_e.hw);
        chk("rs_dirty", rs_dirty, mon_e.dty);
        chk("rs_victim_way", rs_victim_way, mon_e.vw);
        chk("rs_victim_tag", rs_victim_tag, mon_e.vt);
      end
    end
  end

  int n, fd_before, nk;

  initial begin
    pool[0] = 20'hABCDE; pool[1] = 20'h12345; pool[2] = 20'h0F0F0; pool[3] = 20'h00001;
    resetn = 0; idle();
    lk_index = '0; lk_tag = '0; wr_index = '0; wr_way = '0; wr_tag = '0; wr_v = 0; wr_d = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 0);
    chk("reset_rs_valid", rs_valid, 0);
    chk("reset_rs_hit", rs_hit, 0);
    chk("reset_rs_hit_way", rs_hit_way, 0);
    chk("reset_rs_dirty", rs_dirty, 0);
    chk("reset_rs_victim_way", rs_victim_way, 0);
    chk("reset_rs_victim_tag", rs_victim_tag, 0);
    chk("reset_flush_done", flush_done, 0);

    model_clear(); rr = 0;
    resetn = 1;
    sweep_wait(n);
    chk("init_not_ready_cycles", n, SETS);
    chk("init_no_flush_done", flush_done, 0);

    // Directed scenarios
    issue(1, 10, 20'h00055, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 1, 5, 2'b10, 20'hABCDE, 1, 1, 0);
    issue(1, 5, 20'hABCDE, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 9, 20'h12345, 1, 9, 2'b01, 20'h12345, 1, 0, 0);
    issue(0, 0, 0, 1, 3, 2'b01, 20'h11111, 1, 0, 0);
    issue(0, 0, 0, 1, 3, 2'b10, 20'h22222, 1, 1, 0);
    issue(1, 3, 20'h33333, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 1, 20, 2'b01, 20'h44444, 1, 0, 0);
    issue(1, 3, 20'h33333, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 3, 20'h11111, 1, 7, 2'b00, 20'h55555, 1, 1, 0);
    issue(1, 3, 20'h22222, 0, 0, 0, 0, 0, 0, 0);

    random_traffic(1500);

    // Flush with a same-cycle write and lookup
    fd_before = fd_cnt;
    issue(1, 2, pool[0], 1, 2, 2'b01, pool[1], 1, 1, 1);
    sweep_wait(n);
    chk("flush_not_ready_cycles", n, SETS);
    chk("flush_done_on_ready", flush_done, 1);
    @(negedge clk);
    chk("flush_done_one_cycle", flush_done, 0);
    @(posedge clk);
    chk("flush_done_pulses", fd_cnt - fd_before, 1);

    nk = (key_i.size() < 60) ? key_i.size() : 60;
    for (int k = 0; k < nk; k++) issue(1, key_i[k], key_t[k], 0, 0, 0, 0, 0, 0, 0);
    random_traffic(300);

    // Reset in the middle of a flush sweep
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (40) @(negedge clk);
    fd_before = fd_cnt;
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    model_clear(); rr = 0;
    sweep_wait(n);
    chk("reinit_not_ready_cycles", n, SETS);
    repeat (3) @(negedge clk);
    @(posedge clk);
    chk("no_flush_done_after_reset", fd_cnt - fd_before, 0);
    @(negedge clk);

    random_traffic(300);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
